change_dispenser: RTL and testbench

Coin payout unit on the output side of the vending controller. It accepts a change amount over a valid/ready request and pays it out one coin at a time to a coin hopper, using a valid/ack handshake. Coins use the same 2-bit codes as the coin-acceptor input: 1, 2 or 3 units. The block tracks a per-denomination coin inventory and reports either full payment (done) or a shortfall (short, with the unpaid remainder).

---
 rtl/coin_pkg.sv | 26 ++
 rtl/coin_inventory.sv | 33 +++
 rtl/change_dispenser.sv | 155 +++++++++++++++
 tb/tb_change_dispenser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin definitions for the vending controller and the change dispenser.
package coin_pkg;

  // 2-bit coin code, same encoding as the coin-acceptor input
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    THREE = 2'd3
  } coin_t;

  // Value in units of each denomination
  localparam int VAL_ONE   = 1;
  localparam int VAL_TWO   = 2;
  localparam int VAL_THREE = 3;

  // Change dispenser control states
  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    DONE,
    SHORT
  } disp_state_t;

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counter: saturating increment on refill,
// decrement on payout, and no net change when both arrive together.
module coin_inventory #(
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W-1:0] CNT_MAX  = '1;
  localparam logic [INV_W-1:0] CNT_INIT = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] CNT_ONE  = INV_W'(1);

  // Count register: refill saturates at full scale, payout stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= CNT_INIT;
    end else if (inc && !dec) begin
      if (count != CNT_MAX) begin
        count <= count + CNT_ONE;
      end
    end else if (dec && !inc) begin
      if (count != '0) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout unit: takes a change amount, pays it coin by coin to the
// hopper using a greedy largest-coin-first choice, and tracks inventory.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W    = 3,
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_code,
  input  logic             coin_ack,
  input  logic             refill_valid,
  input  logic [1:0]       refill_code,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv1,
  output logic [INV_W-1:0] inv2,
  output logic [INV_W-1:0] inv3
);

  localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(VAL_ONE);
  localparam logic [AMT_W-1:0] AMT_TWO   = AMT_W'(VAL_TWO);
  localparam logic [AMT_W-1:0] AMT_THREE = AMT_W'(VAL_THREE);

  disp_state_t      state;
  disp_state_t      state_next;
  logic [AMT_W-1:0] rem_q;
  coin_t            sel_q;
  coin_t            pick;
  logic             pick_ok;
  logic [AMT_W-1:0] sel_amt;
  logic             accept;
  logic             ack_fire;

  // The coin code doubles as its value in units
  assign sel_amt  = AMT_W'(sel_q);
  assign accept   = (state == IDLE) && req_valid;
  assign ack_fire = (state == ISSUE) && coin_ack;

  // Greedy choice: largest coin that fits the remainder and is in stock
  always_comb begin
    pick    = NONE;
    pick_ok = 1'b0;
    if ((rem_q >= AMT_THREE) && (inv3 != '0)) begin
      pick    = THREE;
      pick_ok = 1'b1;
    end else if ((rem_q >= AMT_TWO) && (inv2 != '0)) begin
      pick    = TWO;
      pick_ok = 1'b1;
    end else if ((rem_q >= AMT_ONE) && (inv1 != '0)) begin
      pick    = ONE;
      pick_ok = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/status outputs decoded from the current state
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    coin_valid = 1'b0;
    coin_code  = 2'd0;
    done       = 1'b0;
    short      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (req_amount == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        state_next = pick_ok ? ISSUE : SHORT;
      end
      ISSUE: begin
        coin_valid = 1'b1;
        coin_code  = sel_q;
        if (coin_ack) begin
          state_next = (rem_q == sel_amt) ? DONE : SELECT;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      SHORT: begin
        short      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Remainder loads on acceptance and drops by the coin value on each ack;
  // the chosen coin is latched in SELECT and held through ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      sel_q <= NONE;
    end else begin
      if (accept) begin
        rem_q <= req_amount;
      end else if (ack_fire) begin
        rem_q <= rem_q - sel_amt;
      end
      if ((state == SELECT) && pick_ok) begin
        sel_q <= pick;
      end
    end
  end

  assign remaining = rem_q;

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv1 (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_valid && (refill_code == ONE)),
    .dec   (ack_fire && (sel_q == ONE)),
    .count (inv1)
  );

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv2 (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_valid && (refill_code == TWO)),
    .dec   (ack_fire && (sel_q == TWO)),
    .count (inv2)
  );

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv3 (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_valid && (refill_code == THREE)),
    .dec   (ack_fire && (sel_q == THREE)),
    .count (inv3)
  );

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: a table of payout requests run back to back
// from reset, followed by hand-written sequences for ack stall, refill
// collision, saturation and reset during a coin ejection.
module tb_change_dispenser;

  localparam int AMT_W    = 3;
  localparam int INV_W    = 4;
  localparam int INV_INIT = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             coin_ack;
  logic             refill_valid = 1'b0;
  logic [1:0]       refill_code = 2'd0;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] inv1;
  logic [INV_W-1:0] inv2;
  logic [INV_W-1:0] inv3;

  // Hopper model: either acks in the same cycle as coin_valid, or is manual
  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  assign coin_ack = auto_ack ? coin_valid : man_ack;

  int checks = 0;
  int errors = 0;

  // One payout request: refills before it, requested amount, expected coin
  // sequence (decimal digits, first coin leftmost), outcome and inventory
  typedef struct {
    int r1;
    int r2;
    int r3;
    int amount;
    int coins;
    int ncoins;
    int done_e;
    int short_e;
    int lat;
    int rem;
    int i1;
    int i2;
    int i3;
  } vec_t;

  vec_t vecs [15];

  change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INV_INIT(INV_INIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_amount   (req_amount),
    .req_ready    (req_ready),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .coin_ack     (coin_ack),
    .refill_valid (refill_valid),
    .refill_code  (refill_code),
    .done         (done),
    .short        (short),
    .remaining    (remaining),
    .inv1         (inv1),
    .inv2         (inv2),
    .inv3         (inv3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_refill(input int code, input int n);
    repeat (n) begin
      @(negedge clk);
      refill_valid = 1'b1;
      refill_code  = 2'(code);
    end
    @(negedge clk);
    refill_valid = 1'b0;
    refill_code  = 2'd0;
  endtask

  task automatic send_req(input string name, input int amt);
    @(negedge clk);
    checkOutput($sformatf("%s ready", name), req_ready, 1);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_amount = '0;
  endtask

  task automatic wait_coin(input string name);
    int k;
    k = 0;
    while (!coin_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput($sformatf("%s coin_valid seen", name), coin_valid, 1);
  endtask

  task automatic checkInv(input string name, input int e1, input int e2, input int e3);
    checkOutput($sformatf("%s inv1", name), inv1, e1);
    checkOutput($sformatf("%s inv2", name), inv2, e2);
    checkOutput($sformatf("%s inv3", name), inv3, e3);
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    int k;
    int got;
    int n;
    logic fin;
    logic saw_done;
    logic saw_short;
    if (v.r1 > 0) do_refill(1, v.r1);
    if (v.r2 > 0) do_refill(2, v.r2);
    if (v.r3 > 0) do_refill(3, v.r3);
    auto_ack = 1'b1;
    send_req(name, v.amount);
    k = 0;
    got = 0;
    n = 0;
    fin = 1'b0;
    saw_done = 1'b0;
    saw_short = 1'b0;
    while (!fin && k < 60) begin
      @(negedge clk);
      k++;
      if (coin_valid) begin
        got = got * 10 + int'(coin_code);
        n++;
      end
      if (done || short) begin
        fin = 1'b1;
        saw_done = done;
        saw_short = short;
      end
    end
    auto_ack = 1'b0;
    checkOutput($sformatf("%s finished", name), fin, 1);
    checkOutput($sformatf("%s coins", name), got, v.coins);
    checkOutput($sformatf("%s ncoins", name), n, v.ncoins);
    checkOutput($sformatf("%s done", name), saw_done, v.done_e);
    checkOutput($sformatf("%s short", name), saw_short, v.short_e);
    checkOutput($sformatf("%s latency", name), k, v.lat);
    @(negedge clk);
    checkOutput($sformatf("%s pulse ends", name), done | short, 0);
    checkOutput($sformatf("%s idle", name), req_ready, 1);
    checkOutput($sformatf("%s remaining", name), remaining, v.rem);
    checkInv(name, v.i1, v.i2, v.i3);
  endtask

  initial begin
    vec_t extra;

    //            r1 r2 r3 amt coins   n  dn sh lat rem i1 i2 i3
    vecs[0]  = '{0, 0, 0, 5, 32,    2, 1, 0, 5,  0,  8, 7, 7};
    vecs[1]  = '{0, 0, 0, 0, 0,     0, 1, 0, 1,  0,  8, 7, 7};
    vecs[2]  = '{0, 0, 0, 6, 33,    2, 1, 0, 5,  0,  8, 7, 5};
    vecs[3]  = '{0, 0, 0, 6, 33,    2, 1, 0, 5,  0,  8, 7, 3};
    vecs[4]  = '{0, 0, 0, 6, 33,    2, 1, 0, 5,  0,  8, 7, 1};
    vecs[5]  = '{0, 0, 0, 7, 322,   3, 1, 0, 7,  0,  8, 5, 0};
    vecs[6]  = '{0, 0, 0, 6, 222,   3, 1, 0, 7,  0,  8, 2, 0};
    vecs[7]  = '{0, 0, 0, 4, 22,    2, 1, 0, 5,  0,  8, 0, 0};
    vecs[8]  = '{0, 0, 0, 4, 1111,  4, 1, 0, 9,  0,  4, 0, 0};
    vecs[9]  = '{0, 0, 0, 4, 1111,  4, 1, 0, 9,  0,  0, 0, 0};
    vecs[10] = '{0, 0, 2, 4, 3,     1, 0, 1, 4,  1,  0, 0, 1};
    vecs[11] = '{1, 0, 0, 2, 1,     1, 0, 1, 4,  1,  0, 0, 1};
    vecs[12] = '{0, 0, 0, 3, 3,     1, 1, 0, 3,  0,  0, 0, 0};
    vecs[13] = '{0, 2, 1, 4, 3,     1, 0, 1, 4,  1,  0, 2, 0};
    vecs[14] = '{3, 0, 0, 7, 22111, 5, 1, 0, 11, 0,  0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst req_ready", req_ready, 1);
    checkOutput("rst coin_valid", coin_valid, 0);
    checkOutput("rst coin_code", coin_code, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst short", short, 0);
    checkOutput("rst remaining", remaining, 0);
    checkInv("rst", 8, 8, 8);
    reset = 1'b0;

    // Ack while idle must not touch the inventory
    @(negedge clk);
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    man_ack = 1'b0;
    checkOutput("idle ack coin_valid", coin_valid, 0);
    checkInv("idle ack", 8, 8, 8);

    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i]);
    end

    // Hopper stalls 10 cycles; new requests during ISSUE are ignored, then the
    // ack lands together with a refill of the same denomination
    do_refill(2, 1);
    checkInv("stall pre", 0, 1, 0);
    send_req("stall", 2);
    wait_coin("stall");
    for (int i = 0; i < 10; i++) begin
      req_valid  = 1'b1;
      req_amount = 3'd7;
      @(negedge clk);
      checkOutput($sformatf("stall%0d coin_valid", i), coin_valid, 1);
      checkOutput($sformatf("stall%0d coin_code", i), coin_code, 2);
      checkOutput($sformatf("stall%0d req_ready", i), req_ready, 0);
    end
    req_valid    = 1'b0;
    req_amount   = '0;
    man_ack      = 1'b1;
    refill_valid = 1'b1;
    refill_code  = 2'd2;
    @(posedge clk);
    #1;
    man_ack      = 1'b0;
    refill_valid = 1'b0;
    refill_code  = 2'd0;
    @(negedge clk);
    checkOutput("stall done", done, 1);
    checkOutput("stall remaining", remaining, 0);
    checkInv("stall collide", 0, 1, 0);
    @(negedge clk);
    checkOutput("stall idle", req_ready, 1);
    checkOutput("stall no queued coin", coin_valid, 0);
    checkOutput("stall no queued amount", remaining, 0);

    // Refill saturation and code-0 refill
    do_refill(3, 20);
    checkInv("saturate", 0, 1, 15);
    do_refill(0, 2);
    checkInv("code0 refill", 0, 1, 15);

    // Reset while a coin is in flight
    send_req("midrst", 3);
    wait_coin("midrst");
    checkOutput("midrst coin_code", coin_code, 3);
    reset = 1'b1;
    #1;
    checkOutput("midrst coin_valid", coin_valid, 0);
    checkOutput("midrst coin_code off", coin_code, 0);
    checkOutput("midrst req_ready", req_ready, 1);
    checkOutput("midrst remaining", remaining, 0);
    checkInv("midrst", 8, 8, 8);
    @(negedge clk);
    reset = 1'b0;

    // Normal payout after recovering from reset
    extra = '{0, 0, 0, 1, 1, 1, 1, 0, 3, 0, 7, 8, 8};
    applyStimulus("post", extra);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
